// File: rtl/dump_pkg.sv
// dump_pkg: shared state encoding and dump-mode constants for the state dump unit.
package dump_pkg;
  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_HALT_WAIT = 3'd1;
  localparam logic [2:0] ST_REGS = 3'd2;
  localparam logic [2:0] ST_MEMS = 3'd3;
  localparam logic [2:0] ST_FIN = 3'd4;
  typedef enum logic [2:0] {
    IDLE = ST_IDLE,
    HALT_WAIT = ST_HALT_WAIT,
    REGS = ST_REGS,
    MEMS = ST_MEMS,
    FIN = ST_FIN
  } state_t;
  localparam logic [1:0] MODE_NONE = 2'b00;
  localparam logic [1:0] MODE_REGS = 2'b01;
  localparam logic [1:0] MODE_MEM = 2'b10;
  localparam logic [1:0] MODE_BOTH = 2'b11;
endpackage

// File: rtl/dump_out_stage.sv
// dump_out_stage: single-entry valid/ready output register with load, hold and drain.
module dump_out_stage #(
  parameter int XLEN = 32,
  parameter int MAW = 12
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load,
  input  logic            ready,
  input  logic [XLEN-1:0] din,
  input  logic            din_mem,
  input  logic [MAW-1:0]  din_index,
  output logic            valid,
  output logic [XLEN-1:0] data,
  output logic            is_mem,
  output logic [MAW-1:0]  index,
  output logic            can_load
);
  assign can_load = !valid || ready;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      valid <= 1'b0;
      data <= '0;
      is_mem <= 1'b0;
      index <= '0;
    end else if (load && can_load) begin
      valid <= 1'b1;
      data <= din;
      is_mem <= din_mem;
      index <= din_index;
    end else if (ready) begin
      valid <= 1'b0;
    end
endmodule

// File: rtl/state_dump_unit.sv
// state_dump_unit: halts the core and streams the register file and/or dmem over valid/ready.
module state_dump_unit
  import dump_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int NREG = 32,
  parameter int RAW = 5,
  parameter int MEM_DEPTH = 4096,
  parameter int MAW = 12
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            start,
  input  logic [1:0]      mode,
  output logic            halt,
  input  logic            halt_ack,
  output logic [RAW-1:0]  reg_raddr,
  input  logic [XLEN-1:0] reg_rdata,
  output logic [MAW-1:0]  mem_raddr,
  input  logic [XLEN-1:0] mem_rdata,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_data,
  output logic            out_is_mem,
  output logic [MAW-1:0]  out_index,
  output logic            busy,
  output logic            done
);
  state_t state;
  logic [1:0] mode_q;
  logic [MAW-1:0] index;
  logic can_load, load, last;
  assign load = (state == REGS || state == MEMS) && can_load;
  assign last = index == ((state == MEMS) ? MAW'(MEM_DEPTH - 1) : MAW'(NREG - 1));
  assign reg_raddr = index[RAW-1:0];
  assign mem_raddr = index;
  dump_out_stage #(.XLEN(XLEN), .MAW(MAW)) u_out (
    .clk(CLK),
    .rst(RST),
    .load(load),
    .ready(out_ready),
    .din((state == MEMS) ? mem_rdata : reg_rdata),
    .din_mem(state == MEMS),
    .din_index(index),
    .valid(out_valid),
    .data(out_data),
    .is_mem(out_is_mem),
    .index(out_index),
    .can_load(can_load)
  );
  // index returns to 0 whenever a section ends, so addresses idle at 0
  always_ff @(posedge CLK or posedge RST)
    if (RST) begin
      state <= IDLE;
      mode_q <= MODE_NONE;
      index <= '0;
      halt <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE:
          if (start) begin
            if (mode != MODE_NONE) begin
              mode_q <= mode;
              halt <= 1'b1;
              busy <= 1'b1;
              state <= HALT_WAIT;
            end else begin
              done <= 1'b1;
            end
          end
        HALT_WAIT:
          if (halt_ack) begin
            index <= '0;
            state <= mode_q[0] ? REGS : MEMS;
          end
        REGS, MEMS:
          if (load) begin
            index <= last ? '0 : index + 1'b1;
            if (last) state <= (state == REGS && mode_q[1]) ? MEMS : FIN;
          end
        FIN:
          if (out_valid && out_ready) begin
            done <= 1'b1;
            halt <= 1'b0;
            busy <= 1'b0;
            state <= IDLE;
          end
        default: state <= IDLE;
      endcase
    end
endmodule
